// File: rtl/aclk_datapath.sv
// Alarm-clock datapath: key entry buffer, time/alarm registers, seconds
// counter with minute tick, registered display mux and alarm detection.
module aclk_datapath #(
  parameter int unsigned SEC_PER_MIN = 60,
  parameter int unsigned NOKEY       = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       shift,
  input  logic       load_new_a,
  input  logic       load_new_c,
  input  logic       reset_count,
  input  logic       show_a,
  input  logic       show_new_time,
  input  logic       alarm_on,
  input  logic       stop_alarm,
  output logic [3:0] ms_hour,
  output logic [3:0] ls_hour,
  output logic [3:0] ms_min,
  output logic [3:0] ls_min,
  output logic       sound_alarm,
  output logic       load_error
);

  logic [15:0] entry_q, entry_d;
  logic [15:0] time_q, time_d;
  logic [15:0] alarm_q, alarm_d;
  logic [15:0] disp_q, disp_d;
  logic [5:0]  sec_q, sec_d;
  logic        match_q, match_d;
  logic        sound_q, sound_d;
  logic        lerr_q, lerr_d;

  logic        entry_valid;
  logic        minute_tick;
  logic        match;
  logic        key_ok;

  // BCD HH:MM advance by one minute, wrapping 23:59 to 00:00.
  function automatic logic [15:0] next_minute(input logic [15:0] t);
    logic [3:0] h1, h0, m1, m0;
    {h1, h0, m1, m0} = t;
    if (m0 != 4'd9) begin
      m0 = m0 + 4'd1;
    end else begin
      m0 = '0;
      if (m1 != 4'd5) begin
        m1 = m1 + 4'd1;
      end else begin
        m1 = '0;
        if (h1 == 4'd2 && h0 == 4'd3) begin
          h1 = '0;
          h0 = '0;
        end else if (h0 == 4'd9) begin
          h0 = '0;
          h1 = h1 + 4'd1;
        end else begin
          h0 = h0 + 4'd1;
        end
      end
    end
    return {h1, h0, m1, m0};
  endfunction

  always_comb begin
    entry_valid = (entry_q[15:12] <= 4'd2) && (entry_q[11:8] <= 4'd9) &&
                  (entry_q[7:4]   <= 4'd5) && (entry_q[3:0]  <= 4'd9) &&
                  ((entry_q[15:12] < 4'd2) || (entry_q[11:8] <= 4'd3));
    key_ok      = (key <= 4'd9) && (key != 4'(NOKEY));
    minute_tick = one_second && !reset_count && (sec_q == 6'(SEC_PER_MIN - 1));
    match       = (time_q == alarm_q);

    entry_d = entry_q;
    time_d  = time_q;
    alarm_d = alarm_q;
    sec_d   = sec_q;
    lerr_d  = 1'b0;

    // Any load clears the buffer and swallows a same-cycle shift.
    if (load_new_a || load_new_c) begin
      entry_d = '0;
      lerr_d  = !entry_valid;
    end else if (shift && key_ok) begin
      entry_d = {entry_q[11:0], key};
    end

    if (load_new_a && entry_valid) alarm_d = entry_q;

    if (reset_count)     sec_d = '0;
    else if (one_second) sec_d = (sec_q == 6'(SEC_PER_MIN - 1)) ? '0 : sec_q + 6'd1;

    // A load request owns the time register even when it is rejected.
    if (load_new_c) begin
      if (entry_valid) time_d = entry_q;
    end else if (minute_tick) begin
      time_d = next_minute(time_q);
    end

    if (show_new_time) disp_d = entry_q;
    else if (show_a)   disp_d = alarm_q;
    else               disp_d = time_q;

    match_d = match;
    if (stop_alarm || !alarm_on)  sound_d = 1'b0;
    else if (match && !match_q)   sound_d = 1'b1;
    else                          sound_d = sound_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      entry_q <= '0;
      time_q  <= '0;
      alarm_q <= '0;
      disp_q  <= '0;
      sec_q   <= '0;
      match_q <= 1'b0;
      sound_q <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      entry_q <= entry_d;
      time_q  <= time_d;
      alarm_q <= alarm_d;
      disp_q  <= disp_d;
      sec_q   <= sec_d;
      match_q <= match_d;
      sound_q <= sound_d;
      lerr_q  <= lerr_d;
    end
  end

  assign {ms_hour, ls_hour, ms_min, ls_min} = disp_q;
  assign sound_alarm = sound_q;
  assign load_error  = lerr_q;

endmodule

// File: tb/tb_aclk_datapath.sv
// Directed bench for aclk_datapath: per-cycle vector table for entry/load/
// display behaviour, then hand sequences for rollover, alarm and reset.
module tb_aclk_datapath;

  localparam int unsigned SPM = 4;
  localparam logic [3:0]  NK  = 4'd10;

  logic       clock = 1'b0;
  logic       reset, one_second, shift, load_new_a, load_new_c, reset_count;
  logic       show_a, show_new_time, alarm_on, stop_alarm;
  logic [3:0] key;
  logic [3:0] ms_hour, ls_hour, ms_min, ls_min;
  logic       sound_alarm, load_error;

  int unsigned total = 0;
  int unsigned bad   = 0;

  aclk_datapath #(.SEC_PER_MIN(SPM), .NOKEY(10)) dut (
    .clock(clock), .reset(reset), .one_second(one_second), .key(key),
    .shift(shift), .load_new_a(load_new_a), .load_new_c(load_new_c),
    .reset_count(reset_count), .show_a(show_a), .show_new_time(show_new_time),
    .alarm_on(alarm_on), .stop_alarm(stop_alarm),
    .ms_hour(ms_hour), .ls_hour(ls_hour), .ms_min(ms_min), .ls_min(ls_min),
    .sound_alarm(sound_alarm), .load_error(load_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [3:0]  k;
    logic        sh, lda, ldc, rc, sa, snt;
    logic [15:0] disp;
    logic        lerr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rst, logic [3:0] k, logic sh, logic lda,
                              logic ldc, logic rc, logic sa, logic snt,
                              logic [15:0] disp, logic lerr);
    vec_t v;
    v.rst = rst; v.k = k; v.sh = sh; v.lda = lda; v.ldc = ldc; v.rc = rc;
    v.sa = sa; v.snt = snt; v.disp = disp; v.lerr = lerr;
    return v;
  endfunction

  function automatic logic [15:0] disp();
    return {ms_hour, ls_hour, ms_min, ls_min};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [3:0] k);
    key = k; shift = 1'b1;
    step();
    shift = 1'b0; key = NK;
  endtask

  task automatic push4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    push(a); push(b); push(c); push(d);
  endtask

  task automatic load_c();
    load_new_c = 1'b1; reset_count = 1'b1;
    step();
    load_new_c = 1'b0; reset_count = 1'b0;
  endtask

  task automatic load_a();
    load_new_a = 1'b1;
    step();
    load_new_a = 1'b0;
  endtask

  task automatic pulse();
    one_second = 1'b1;
    step();
    one_second = 1'b0;
  endtask

  initial begin
    reset = 1'b1; one_second = 1'b0; key = NK; shift = 1'b0;
    load_new_a = 1'b0; load_new_c = 1'b0; reset_count = 1'b0;
    show_a = 1'b0; show_new_time = 1'b0; alarm_on = 1'b0; stop_alarm = 1'b0;

    //         rst k     sh lda ldc rc sa snt disp      lerr
    vt.push_back(mk(1, NK,   0, 0, 0, 0, 0, 0, 16'h0000, 0));
    vt.push_back(mk(0, 4'd1, 1, 0, 0, 0, 0, 1, 16'h0000, 0));
    vt.push_back(mk(0, 4'd2, 1, 0, 0, 0, 0, 1, 16'h0001, 0));
    vt.push_back(mk(0, 4'd3, 1, 0, 0, 0, 0, 1, 16'h0012, 0));
    vt.push_back(mk(0, 4'd0, 1, 0, 0, 0, 0, 1, 16'h0123, 0));
    vt.push_back(mk(0, NK,   0, 0, 1, 1, 0, 1, 16'h1230, 0));
    vt.push_back(mk(0, NK,   0, 0, 0, 0, 0, 0, 16'h1230, 0));
    vt.push_back(mk(0, NK,   0, 0, 0, 0, 0, 1, 16'h0000, 0));
    vt.push_back(mk(0, NK,   1, 0, 0, 0, 0, 1, 16'h0000, 0));
    vt.push_back(mk(0, 4'd5, 1, 0, 0, 0, 0, 1, 16'h0000, 0));
    vt.push_back(mk(0, NK,   1, 0, 0, 0, 0, 1, 16'h0005, 0));
    vt.push_back(mk(0, 4'd7, 1, 0, 1, 0, 0, 1, 16'h0005, 0));
    vt.push_back(mk(0, NK,   0, 0, 0, 0, 0, 1, 16'h0000, 0));
    vt.push_back(mk(0, NK,   0, 0, 0, 0, 0, 0, 16'h0005, 0));
    vt.push_back(mk(0, 4'd2, 1, 0, 0, 0, 1, 0, 16'h0000, 0));
    vt.push_back(mk(0, 4'd4, 1, 0, 0, 0, 1, 0, 16'h0000, 0));
    vt.push_back(mk(0, 4'd0, 1, 0, 0, 0, 1, 0, 16'h0000, 0));
    vt.push_back(mk(0, 4'd0, 1, 0, 0, 0, 1, 0, 16'h0000, 0));
    vt.push_back(mk(0, NK,   0, 1, 0, 0, 1, 0, 16'h0000, 1));
    vt.push_back(mk(0, NK,   0, 0, 0, 0, 0, 1, 16'h0000, 0));
    vt.push_back(mk(0, NK,   0, 0, 0, 0, 1, 0, 16'h0000, 0));
    vt.push_back(mk(0, 4'd1, 1, 0, 0, 0, 1, 0, 16'h0000, 0));
    vt.push_back(mk(0, NK,   0, 0, 0, 0, 1, 1, 16'h0001, 0));
    vt.push_back(mk(0, NK,   0, 0, 0, 0, 1, 0, 16'h0000, 0));

    for (int i = 0; i < vt.size(); i++) begin
      reset = vt[i].rst; key = vt[i].k; shift = vt[i].sh;
      load_new_a = vt[i].lda; load_new_c = vt[i].ldc; reset_count = vt[i].rc;
      show_a = vt[i].sa; show_new_time = vt[i].snt;
      step();
      chk($sformatf("vec%0d_disp", i), disp(), vt[i].disp);
      chk($sformatf("vec%0d_lerr", i), 16'(load_error), 16'(vt[i].lerr));
      chk($sformatf("vec%0d_sound", i), 16'(sound_alarm), 16'h0);
    end
    reset = 1'b0; key = NK; shift = 1'b0; load_new_a = 1'b0; load_new_c = 1'b0;
    reset_count = 1'b0; show_a = 1'b0; show_new_time = 1'b0;

    // 23:59 rollover and seconds counting
    push4(4'd2, 4'd3, 4'd5, 4'd9);
    load_c();
    pulse(); pulse(); pulse();
    chk("pre_wrap", disp(), 16'h2359);
    pulse(); step();
    chk("wrap_2359", disp(), 16'h0000);
    pulse(); pulse(); pulse(); step();
    chk("sec_no_early_tick", disp(), 16'h0000);
    pulse(); step();
    chk("tick_0001", disp(), 16'h0001);
    pulse(); pulse(); pulse();
    one_second = 1'b1; reset_count = 1'b1; step();
    one_second = 1'b0; reset_count = 1'b0; step();
    chk("rc_suppress", disp(), 16'h0001);
    pulse(); pulse(); pulse(); step();
    chk("rc_restart", disp(), 16'h0001);
    pulse(); step();
    chk("rc_tick", disp(), 16'h0002);

    // Invalid minute-tens digit rejected
    push4(4'd1, 4'd9, 4'd6, 4'd0);
    load_c();
    chk("lerr_em1", 16'(load_error), 16'h1);
    step();
    chk("lerr_one_cycle", 16'(load_error), 16'h0);
    chk("time_hold", disp(), 16'h0002);

    // Alarm at 07:00 from 06:59
    push4(4'd0, 4'd7, 4'd0, 4'd0);
    load_a();
    push4(4'd0, 4'd6, 4'd5, 4'd9);
    load_c();
    alarm_on = 1'b1;
    pulse(); pulse(); pulse();
    chk("no_sound_0659", 16'(sound_alarm), 16'h0);
    pulse();
    chk("no_sound_yet", 16'(sound_alarm), 16'h0);
    step();
    chk("sound_0700", 16'(sound_alarm), 16'h1);
    pulse(); pulse(); pulse(); pulse(); step();
    chk("time_0701", disp(), 16'h0701);
    chk("sound_hold", 16'(sound_alarm), 16'h1);
    stop_alarm = 1'b1; step();
    chk("stop_alarm", 16'(sound_alarm), 16'h0);
    stop_alarm = 1'b0; step();
    chk("stays_off", 16'(sound_alarm), 16'h0);
    push4(4'd0, 4'd7, 4'd0, 4'd0);
    load_c(); step();
    chk("load_match", 16'(sound_alarm), 16'h1);
    alarm_on = 1'b0; step();
    chk("alarm_off", 16'(sound_alarm), 16'h0);

    // Reset overrides a concurrent load and shift
    push4(4'd1, 4'd2, 4'd3, 4'd0);
    load_c();
    show_a = 1'b1; step();
    chk("show_alarm", disp(), 16'h0700);
    reset = 1'b1; load_new_c = 1'b1; shift = 1'b1; key = 4'd5; step();
    reset = 1'b0; load_new_c = 1'b0; shift = 1'b0; key = NK;
    chk("rst_disp", disp(), 16'h0000);
    chk("rst_sound", 16'(sound_alarm), 16'h0);
    chk("rst_lerr", 16'(load_error), 16'h0);
    show_a = 1'b0; step();
    chk("rst_time", disp(), 16'h0000);
    show_a = 1'b1; step();
    chk("rst_alarm", disp(), 16'h0000);
    show_a = 1'b0; show_new_time = 1'b1; step();
    chk("rst_entry", disp(), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aclk_datapath.md
AClk_DATAPATH -- requirements
Module: aclk_datapath

Interface
REQ-001 SHALL have parameter SEC_PER_MIN, default 60: one_second pulses per minute; range 2..63.
REQ-002 SHALL have parameter NOKEY, default 10: key code meaning no key pressed.
REQ-003 SHALL use one clock and one reset: reset is synchronous and active-high.
REQ-004 clock  in  1  rising-edge system clock.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 one_second  in  1  single-cycle pulse, once per second.
REQ-007 key  in  4  current key code: 0-9 are digits, NOKEY means idle.
REQ-008 shift  in  1  shift key into entry buffer.
REQ-009 load_new_a  in  1  load entry buffer into alarm register.
REQ-010 load_new_c  in  1  load entry buffer into current time.
REQ-011 reset_count  in  1  clear seconds counter.
REQ-012 show_a, show_new_time  in  1 each  display source select.
REQ-013 alarm_on  in  1  alarm enable switch; stop_alarm  in  1  silences the alarm.
REQ-014 ms_hour, ls_hour, ms_min, ls_min  out  4 each  registered BCD display digits.
REQ-015 sound_alarm  out  1  alarm active (registered); load_error  out  1  one-cycle pulse when a load is rejected.

Function
REQ-016 Entry buffer SHALL hold 4 BCD digits (eh1, eh0, em1, em0).
REQ-017 On shift with key<=9 the buffer SHALL shift left: eh1<=eh0, eh0<=em1, em1<=em0, em0<=key.
REQ-018 On shift with key>9 the buffer SHALL hold.
REQ-019 Time and alarm registers SHALL each hold HH:MM as 4 BCD digits in the range 00:00..23:59.
REQ-020 A buffer value SHALL be valid iff eh1<=2, eh0<=9, em1<=5, em0<=9, and (eh1<2 or eh0<=3).
REQ-021 On load_new_c with a valid buffer, the time register SHALL take the buffer value at that edge.
REQ-022 On load_new_a with a valid buffer, the alarm register SHALL take the buffer value at that edge.
REQ-023 On either load with an invalid buffer, the target register SHALL hold and load_error SHALL pulse high for 1 cycle on the next edge.
REQ-024 Any load_new_a or load_new_c SHALL clear the buffer to 0000 at the same edge, valid or not.
REQ-025 If a load and shift occur in the same cycle, the load SHALL win and the shift SHALL be ignored.
REQ-026 Seconds counter SHALL run 0..SEC_PER_MIN-1 and SHALL increment on one_second.
REQ-027 At SEC_PER_MIN-1 with one_second, the seconds counter SHALL wrap to 0 and raise an internal minute tick in the same cycle.
REQ-028 reset_count SHALL force seconds to 0 and suppress the minute tick, overriding one_second.
REQ-029 A minute tick SHALL increment time in BCD: min 59 -> 00 with hour+1; 23:59 -> 00:00.
REQ-030 load_new_c SHALL override a minute tick in the same cycle.
REQ-031 Display source priority SHALL be show_new_time (buffer) > show_a (alarm) > time.
REQ-032 Display outputs SHALL be registered, with 1-cycle latency from a select change or source change.
REQ-033 match SHALL mean time==alarm; the block SHALL register match_d.
REQ-034 sound_alarm SHALL set on a cycle where match & !match_d & alarm_on.
REQ-035 sound_alarm SHALL clear when stop_alarm=1 or alarm_on=0; clear SHALL win over set.
REQ-036 Loading time or alarm so that match becomes true SHALL also trigger the alarm via rising-edge detection.

Reset
REQ-037 Reset SHALL set time, alarm, buffer, seconds, display outputs and match_d to 0; sound_alarm=0; load_error=0.
REQ-038 Reset SHALL override every other input in the same cycle, including mid-load and mid-shift.

Verification
REQ-039 Shift keys 1,2,3,0 then load_new_c=1 & reset_count=1 -> next cycle time=12:30, seconds=0, buffer=0000; with show_new_time=0 and show_a=0, display shows 1,2,3,0 one cycle later.
REQ-040 Time 23:59, seconds=SEC_PER_MIN-1, one_second pulse -> time=00:00, seconds=0.
REQ-041 Buffer 2,4,0,0 then load_new_a -> alarm unchanged, load_error pulses high for exactly 1 cycle, buffer=0000.
REQ-042 Alarm=07:00, alarm_on=1, time 06:59 advances -> sound_alarm=1 next cycle; it stays 1 while the time advances to 07:01; stop_alarm=1 -> sound_alarm=0.
REQ-043 Shift with key=NOKEY -> buffer unchanged; shift and load_new_c in the same cycle -> key ignored, buffer=0000.
REQ-044 Reset asserted while time=12:30 and show_a=1 -> next cycle all outputs 0 and time=00:00.
